// File: rtl/midi_decoder_if.sv
// Received MIDI byte stream: one byte per byte_valid strobe.

interface midi_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;

  modport master (output byte_in, output byte_valid);
  modport slave  (input  byte_in, input  byte_valid);
endinterface

// File: rtl/midi_decoder.sv
// MIDI note decoder: turns a received MIDI byte stream into note on/off events,
// honouring running status, realtime interleaving and channel filtering.

package MIDI;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   note_number;
    logic [6:0]   velocity;
  } note_change_t;
endpackage

module midi_decoder #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic               clock_50_000_000,
  input  logic               reset_l,
  midi_decoder_if.slave      bus,
  output MIDI::note_change_t note,
  output logic               note_ready,
  output logic               protocol_error
);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSkip} state_e;

  state_e             state_q, state_d;
  logic [7:0]         status_q, status_d;
  logic [6:0]         pending_q, pending_d;
  MIDI::note_change_t note_q, note_d;
  logic               note_ready_q, note_ready_d;
  logic               error_q, error_d;

  logic is_data, is_chan, is_sys, is_note, chan_ok, rs_note, emit;

  always_comb begin
    is_data = bus.byte_valid && !bus.byte_in[7];
    is_chan = bus.byte_valid && bus.byte_in[7] && (bus.byte_in[7:4] != 4'hF);
    is_sys  = bus.byte_valid && (bus.byte_in[7:3] == 5'b11110);
    is_note = (bus.byte_in[7:5] == 3'b100);
    chan_ok = OMNI || (bus.byte_in[3:0] == CHANNEL);
    // Guard on the latched status too, so a stray state can never emit garbage.
    rs_note = (status_q[7:5] == 3'b100) && (OMNI || (status_q[3:0] == CHANNEL));
    emit    = is_data && (state_q == StWaitD2) && rs_note;
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= StIdle;
      status_q     <= 8'h00;
      pending_q    <= 7'd0;
      note_q       <= '{status: MIDI::OFF, note_number: 7'd0, velocity: 7'd0};
      note_ready_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      pending_q    <= pending_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
      error_q      <= error_d;
    end
  end

  // Realtime bytes match none of the classes below and so leave everything untouched.
  always_comb begin
    state_d = state_q;
    if (is_chan) begin
      state_d = (is_note && chan_ok) ? StWaitD1 : StSkip;
    end else if (is_sys) begin
      state_d = (bus.byte_in == 8'hF7) ? StIdle : StSkip;
    end else if (is_data) begin
      unique case (state_q)
        StWaitD1: state_d = StWaitD2;
        StWaitD2: state_d = StWaitD1;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    status_d     = status_q;
    pending_d    = pending_q;
    note_d       = note_q;
    note_ready_d = 1'b0;
    error_d      = 1'b0;
    if (is_chan) begin
      status_d = bus.byte_in;
    end else if (is_sys) begin
      status_d = 8'h00;
    end
    if ((is_chan || is_sys) && (state_q == StWaitD2)) begin
      error_d   = 1'b1;
      pending_d = 7'd0;
    end
    if (is_data && (state_q == StWaitD1)) begin
      pending_d = bus.byte_in[6:0];
    end
    if (emit) begin
      note_d.status      = (status_q[4] && (bus.byte_in[6:0] != 7'd0)) ? MIDI::ON : MIDI::OFF;
      note_d.note_number = pending_q;
      note_d.velocity    = bus.byte_in[6:0];
      note_ready_d       = 1'b1;
    end
  end

  assign note           = note_q;
  assign note_ready     = note_ready_q;
  assign protocol_error = error_q;

endmodule
